digit_update_arbiter: RTL and testbench

DIGIT_UPDATE_ARBITER -- requirements
Module: digit_update_arbiter

---
 rtl/adv_counter_pkg.sv | 20 ++
 rtl/digit_update_arbiter_rr_picker.sv | 29 ++
 rtl/digit_update_arbiter.sv | 128 ++++++++++++
 tb/tb_digit_update_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adv_counter_pkg.sv
// Shared state encoding, defaults and timer width for the digit update arbiter.
package adv_counter_pkg;

  localparam int unsigned DIGITS_DEF     = 6;
  localparam int unsigned SETTLE_MAX_DEF = 16;
  localparam int unsigned TIMER_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_REFRESH   = 2'd3
  } state_e;

  // Index width that stays legal for a single-digit build.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_update_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending digit after last_grant, wrapping.
module rr_picker
  import adv_counter_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  localparam int unsigned IW    = idx_w(DIGITS)
) (
  input  logic [DIGITS-1:0] pending,
  input  logic [IW-1:0]     last_grant,
  output logic [IW-1:0]     index,
  output logic              found
);

  logic [IW-1:0] cand;

  always_comb begin
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= DIGITS; k++) begin
      cand = IW'((32'(last_grant) + k) % DIGITS);
      if (!found && pending[cand]) begin
        index = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_update_arbiter.sv
// Serialises per-digit increment requests onto one shared BCD counter port.
// Optional ADV_COUNTER_REFRESH_BATCH_EN: one refresh strobe per burst instead of per grant.
module digit_update_arbiter
  import adv_counter_pkg::*;
#(
  parameter int unsigned DIGITS     = DIGITS_DEF,
  parameter int unsigned SETTLE_MAX = SETTLE_MAX_DEF,
  localparam int unsigned IW        = idx_w(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] req,
  output logic              upd_valid,
  output logic [IW-1:0]     upd_digit,
  input  logic              upd_done,
  output logic              ref_pulse,
  output logic [DIGITS-1:0] pending,
  output logic              busy,
  output logic              timeout_err
);

  state_e              state_q, state_d;
  logic [DIGITS-1:0]   pending_q, pending_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [IW-1:0]       upd_digit_q, upd_digit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                upd_valid_q, upd_valid_d;
  logic                ref_pulse_q, ref_pulse_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic                wait_end_c;
  logic [IW-1:0]       pick_idx_c;
  logic                pick_found_c;

  rr_picker #(.DIGITS(DIGITS)) u_picker (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .index      (pick_idx_c),
    .found      (pick_found_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | req;
    last_grant_d  = last_grant_q;
    upd_digit_d   = upd_digit_q;
    timer_d       = timer_q;
    upd_valid_d   = 1'b0;
    ref_pulse_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    wait_end_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          state_d     = ST_GRANT;
          upd_digit_d = pick_idx_c;
          upd_valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        // A fresh request on the granted digit survives the clear.
        pending_d    = (pending_q & ~(DIGITS'(1) << upd_digit_q)) | req;
        last_grant_d = upd_digit_q;
        timer_d      = '0;
        state_d      = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (upd_done) begin
          wait_end_c = 1'b1;
        end else if (timer_q == TIMER_W'(SETTLE_MAX - 1)) begin
          timeout_err_d = 1'b1;
          wait_end_c    = 1'b1;
        end else if (timer_q != {TIMER_W{1'b1}}) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_REFRESH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wait_end_c) begin
`ifdef ADV_COUNTER_REFRESH_BATCH_EN
      state_d = (|pending_d) ? ST_IDLE : ST_REFRESH;
`else
      state_d = ST_REFRESH;
`endif
      ref_pulse_d = (state_d == ST_REFRESH);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      last_grant_q  <= IW'(DIGITS - 1);
      upd_digit_q   <= '0;
      timer_q       <= '0;
      upd_valid_q   <= 1'b0;
      ref_pulse_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      upd_digit_q   <= upd_digit_d;
      timer_q       <= timer_d;
      upd_valid_q   <= upd_valid_d;
      ref_pulse_q   <= ref_pulse_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_digit   = upd_digit_q;
  assign ref_pulse   = ref_pulse_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_digit_update_arbiter.sv
// Scoreboard bench for digit_update_arbiter: expected grants queued by stimulus, popped by a monitor.
module tb_digit_update_arbiter;

  localparam int DIGITS = 6;
`ifdef ADV_COUNTER_REFRESH_BATCH_EN
  localparam int FAIR_REFS = 1;
`else
  localparam int FAIR_REFS = 6;
`endif

  typedef struct {
    int digit;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIGITS-1:0] req = '1;
  logic              upd_done = 1'b0;
  logic              upd_valid;
  logic [2:0]        upd_digit;
  logic              ref_pulse;
  logic [DIGITS-1:0] pending;
  logic              busy;
  logic              timeout_err;

  int   cyc = 0;
  int   done_at = -1;
  int   done_delay = 0;
  int   ref_cnt = 0;
  int   last_ref_cyc = 0;
  int   last_valid_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_grant[$];
  exp_t e;
  int   r0, ref0;

  digit_update_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .upd_valid   (upd_valid),
    .upd_digit   (upd_digit),
    .upd_done    (upd_done),
    .ref_pulse   (ref_pulse),
    .pending     (pending),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Counter-side responder: one-cycle upd_done at the scheduled cycle.
  always @(posedge clk) begin
    #1;
    upd_done = (cyc == done_at);
  end

  // Monitor: pop the expected grant on every upd_valid, count refresh strobes.
  always @(negedge clk) begin
    if (upd_valid) begin
      last_valid_cyc = cyc;
      done_at = (done_delay > 0) ? cyc + done_delay : -1;
      if (exp_grant.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant: digit %0d at cycle %0d, no grant expected", upd_digit, cyc);
      end else begin
        e = exp_grant.pop_front();
        check("grant_digit", 32'(upd_digit), e.digit);
        if (e.cyc >= 0) check("grant_cycle", cyc, e.cyc);
      end
    end
    if (ref_pulse) begin
      ref_cnt++;
      last_ref_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req   = '1;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (!busy && pending == '0 && exp_grant.size() == 0) ok = 1'b1;
    end
    check(name, 32'(ok), 1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests asserted: all dropped.
    do_reset(3);
    @(negedge clk);
    check("rst_pending", 32'(pending), 0);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_upd_digit", 32'(upd_digit), 0);
    check("rst_ref_pulse", 32'(ref_pulse), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    step();
    step();
    @(negedge clk);
    check("rst_req_dropped", 32'(pending), 0);
    step();

    // Single request on digit 2, counter answers 3 cycles after the grant.
    done_delay = 3;
    r0 = cyc;
    ref0 = ref_cnt;
    req = 6'b000100;
    exp_grant.push_back('{2, r0 + 2});
    step();
    req = '0;
    wait_idle("single_idle", 60);
    check("single_ref_count", ref_cnt - ref0, 1);
    check("single_ref_latency", last_ref_cyc - last_valid_cyc, 4);
    check("single_timeout_err", 32'(timeout_err), 0);

    // Fairness from reset: all digits at once, granted 0..5.
    do_reset(1);
    done_delay = 2;
    r0 = cyc;
    ref0 = ref_cnt;
    req = '1;
    exp_grant.push_back('{0, r0 + 2});
    for (int d = 1; d < DIGITS; d++) exp_grant.push_back('{d, -1});
    step();
    req = '0;
    wait_idle("fair_idle", 200);
    check("fair_ref_count", ref_cnt - ref0, FAIR_REFS);
    check("fair_timeout_err", 32'(timeout_err), 0);

    // Timeout: no upd_done; wait lasts 16 cycles, refresh still follows.
    done_delay = 0;
    r0 = cyc;
    ref0 = ref_cnt;
    req = 6'b000010;
    exp_grant.push_back('{1, r0 + 2});
    step();
    req = '0;
    wait_idle("timeout_idle", 60);
    check("timeout_ref_count", ref_cnt - ref0, 1);
    check("timeout_ref_latency", last_ref_cyc - last_valid_cyc, 17);
    check("timeout_err_set", 32'(timeout_err), 1);

    // Set beats clear: req[3] again in its own GRANT cycle.
    done_delay = 2;
    r0 = cyc;
    req = 6'b001000;
    exp_grant.push_back('{3, r0 + 2});
    exp_grant.push_back('{3, -1});
    step();
    req = '0;
    step();
    req = 6'b001000;
    step();
    req = '0;
    @(negedge clk);
    check("sbc_pending3", 32'(pending[3]), 1);
    step();
    wait_idle("sbc_idle", 80);
    check("timeout_err_sticky", 32'(timeout_err), 1);

    // Reset during WAIT_DONE, late upd_done must be ignored.
    done_delay = 0;
    r0 = cyc;
    req = 6'b010000;
    exp_grant.push_back('{4, r0 + 2});
    step();
    req = '0;
    step();
    step();
    step();
    ref0 = ref_cnt;
    rst_n = 1'b0;
    done_at = cyc + 1;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("midrst_ref_count", ref_cnt - ref0, 0);
    check("midrst_pending", 32'(pending), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_timeout_clr", 32'(timeout_err), 0);
    step();
    done_delay = 2;
    r0 = cyc;
    req = 6'b010001;
    exp_grant.push_back('{0, r0 + 2});
    exp_grant.push_back('{4, -1});
    step();
    req = '0;
    wait_idle("midrst_idle", 80);

    check("exp_queue_empty", 32'(exp_grant.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
